cart_bus_mux: RTL

CART_BUS_MUX -- requirements
Module: cart_bus_mux

---
 rtl/cart_bus_mux.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/cart_bus_mux.sv
// cart_bus_mux -- selects one of NCH cartridge mapper channels onto the shared
// cartridge bus. A new one-hot request must stay constant for STABLE_CYC cycles
// and is then followed by GUARD_CYC cycles of forced-idle bus before the new
// channel is committed. Channel 0 is the default mapper.
//
// Ports:
//   mclk, rst_n        clock, asynchronous active-low reset
//   map_active         one-hot request, bit k selects channel k+1
//   ch_*               per-channel flattened bus inputs, channel i in slice i
//   di .. bsram_rd_n   muxed bus of the committed channel (idle during GUARD)
//   sel                committed channel index
//   switching          high while a switch is settling or guarding
//   map_err            sticky flag, set by any multi-hot request
module cart_bus_mux #(
  parameter int NCH        = 6,
  parameter int STABLE_CYC = 4,
  parameter int GUARD_CYC  = 2
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic [NCH-2:0]    map_active,
  input  logic [NCH*8-1:0]  ch_do,
  input  logic [NCH-1:0]    ch_irq_n,
  input  logic [NCH*24-1:0] ch_rom_addr,
  input  logic [NCH-1:0]    ch_rom_ce_n,
  input  logic [NCH-1:0]    ch_rom_oe_n,
  input  logic [NCH-1:0]    ch_rom_word,
  input  logic [NCH*20-1:0] ch_bsram_addr,
  input  logic [NCH*8-1:0]  ch_bsram_d,
  input  logic [NCH-1:0]    ch_bsram_ce_n,
  input  logic [NCH-1:0]    ch_bsram_oe_n,
  input  logic [NCH-1:0]    ch_bsram_we_n,
  input  logic [NCH-1:0]    ch_bsram_rd_n,
  output logic [7:0]        di,
  output logic              irq_n,
  output logic [23:0]       rom_addr,
  output logic              rom_ce_n,
  output logic              rom_oe_n,
  output logic              rom_word,
  output logic [19:0]       bsram_addr,
  output logic [7:0]        bsram_d,
  output logic              bsram_ce_n,
  output logic              bsram_oe_n,
  output logic              bsram_we_n,
  output logic              bsram_rd_n,
  output logic [2:0]        sel,
  output logic              switching,
  output logic              map_err
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_SETTLE = 2'd1, ST_GUARD = 2'd2} state_t;

  typedef struct packed {
    logic [7:0]  data;
    logic        irq_n;
    logic [23:0] rom_addr;
    logic        rom_ce_n;
    logic        rom_oe_n;
    logic        rom_word;
    logic [19:0] bsram_addr;
    logic [7:0]  bsram_d;
    logic        bsram_ce_n;
    logic        bsram_oe_n;
    logic        bsram_we_n;
    logic        bsram_rd_n;
  } ch_bus_t;

  localparam ch_bus_t IDLE_BUS = '{data: 8'hFF, irq_n: 1'b1, rom_addr: 24'h000000,
                                   rom_ce_n: 1'b1, rom_oe_n: 1'b1, rom_word: 1'b0,
                                   bsram_addr: 20'h00000, bsram_d: 8'h00,
                                   bsram_ce_n: 1'b1, bsram_oe_n: 1'b1,
                                   bsram_we_n: 1'b1, bsram_rd_n: 1'b1};
  localparam logic [3:0] STABLE_N = 4'(STABLE_CYC);
  localparam logic [3:0] GUARD_N  = 4'(GUARD_CYC);

  // Returns {multi_hot, channel}; a multi-hot or empty request maps to channel 0,
  // and the result can never exceed NCH-1.
  function automatic logic [3:0] decode_req(input logic [NCH-2:0] m);
    logic [2:0] idx;
    logic       seen;
    logic       multi;
    idx   = 3'd0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int k = 0; k < NCH - 1; k++) begin
      if (m[k]) begin
        if (seen) begin
          multi = 1'b1;
        end else begin
          seen = 1'b1;
          idx  = 3'(k + 1);
        end
      end
    end
    if (multi) begin
      idx = 3'd0;
    end
    return {multi, idx};
  endfunction

  state_t     state_r, state_s;
  logic [2:0] sel_r, sel_s;
  logic [2:0] cand_r, cand_s;
  logic [3:0] cnt_r, cnt_s;
  logic       map_err_r;
  logic [3:0] dec_s;
  logic [2:0] req_s;
  logic       multi_s;
  ch_bus_t    ch_arr_s [8];
  ch_bus_t    bus_s;

  assign dec_s   = decode_req(map_active);
  assign req_s   = dec_s[2:0];
  assign multi_s = dec_s[3];

  // Unpack the flattened channel inputs; unused table slots read as idle so the
  // 3-bit select always addresses a defined entry.
  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NCH) begin : g_used
      assign ch_arr_s[i] = '{data: ch_do[i*8 +: 8], irq_n: ch_irq_n[i],
                             rom_addr: ch_rom_addr[i*24 +: 24],
                             rom_ce_n: ch_rom_ce_n[i], rom_oe_n: ch_rom_oe_n[i],
                             rom_word: ch_rom_word[i],
                             bsram_addr: ch_bsram_addr[i*20 +: 20],
                             bsram_d: ch_bsram_d[i*8 +: 8],
                             bsram_ce_n: ch_bsram_ce_n[i], bsram_oe_n: ch_bsram_oe_n[i],
                             bsram_we_n: ch_bsram_we_n[i], bsram_rd_n: ch_bsram_rd_n[i]};
    end else begin : g_unused
      assign ch_arr_s[i] = IDLE_BUS;
    end
  end

  // Next-state logic for the debounce / guard switch sequence.
  always_comb begin
    state_s = state_r;
    sel_s   = sel_r;
    cand_s  = cand_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (req_s != sel_r) begin
          state_s = ST_SETTLE;
          cand_s  = req_s;
          cnt_s   = 4'd1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_SETTLE: begin
        if (req_s == sel_r) begin
          // Request fell back to the committed channel: abort, bus never idled.
          state_s = ST_RUN;
        end else if (req_s != cand_r) begin
          cand_s = req_s;
          cnt_s  = 4'd1;
        end else if (cnt_r == STABLE_N) begin
          state_s = ST_GUARD;
          cnt_s   = 4'd1;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ST_GUARD: begin
        // Requests are ignored here; the candidate is committed at the end.
        if (cnt_r == GUARD_N) begin
          state_s = ST_RUN;
          sel_s   = cand_r;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // Switch FSM registers and sticky multi-hot error flag.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      sel_r     <= 3'd0;
      cand_r    <= 3'd0;
      cnt_r     <= 4'd0;
      map_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      cand_r    <= cand_s;
      cnt_r     <= cnt_s;
      map_err_r <= map_err_r | multi_s;
    end
  end

  // Zero-latency bus mux of the committed channel, forced idle while guarding.
  always_comb begin
    bus_s = ch_arr_s[sel_r];
    if (state_r == ST_GUARD) begin
      bus_s = IDLE_BUS;
    end else begin
      bus_s = ch_arr_s[sel_r];
    end
  end

  assign di         = bus_s.data;
  assign irq_n      = bus_s.irq_n;
  assign rom_addr   = bus_s.rom_addr;
  assign rom_ce_n   = bus_s.rom_ce_n;
  assign rom_oe_n   = bus_s.rom_oe_n;
  assign rom_word   = bus_s.rom_word;
  assign bsram_addr = bus_s.bsram_addr;
  assign bsram_d    = bus_s.bsram_d;
  assign bsram_ce_n = bus_s.bsram_ce_n;
  assign bsram_oe_n = bus_s.bsram_oe_n;
  assign bsram_we_n = bus_s.bsram_we_n;
  assign bsram_rd_n = bus_s.bsram_rd_n;
  assign sel        = sel_r;
  assign switching  = (state_r != ST_RUN);
  assign map_err    = map_err_r;

endmodule
